// File: rtl/reset_responder_pkg.sv
// rtl/reset_responder_pkg.sv - shared state encoding and synchronizer limits
package reset_responder_pkg;

   // Responder states; encodings are fixed so every 2-bit value is a named state
   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_WAIT_REL = 2'd1,
      ST_WAIT_RDY = 2'd2,
      ST_RUN      = 2'd3
   } state_e;

   // Fewer than two flops gives no metastability settling time
   localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/reset_responder_sync_bit.sv
// rtl/reset_responder_sync_bit.sv - N-stage single-bit synchronizer with async reset to 0
module sync_bit
   import reset_responder_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   // Depth is never allowed below the safe minimum, whatever the caller asks for
   localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

   logic [N-1:0] sync_q;

   // Shift the asynchronous level through the chain; reset clears every stage
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[N-2:0], d_i};
      end
   end

   assign q_o = sync_q[N-1];

endmodule

// File: rtl/reset_responder.sv
// rtl/reset_responder.sv - destination endpoint: sync request, hold local reset, toggle ack
module reset_responder
   import reset_responder_pkg::*;
#(
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic REQ_IN,
   input  logic READY_IN,
   output logic OUT_RST,
   output logic OUT_RST_N,
   output logic BUSY,
   output logic ACK_TOGGLE
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   logic             req_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ack_q, ack_d;
   logic             out_rst_q;
   logic             busy_q;

   sync_bit #(
      .STAGES(SYNC_STAGES)
   ) u_req_sync (
      .clk_i(CLK),
      .rst_i(RST),
      .d_i  (REQ_IN),
      .q_o  (req_s)
   );

   // Next-state, hold counter and ack toggle; a request always beats READY_IN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      case (state_q)
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_WAIT_REL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_REL: begin
            if (!req_s) begin
               state_d = ST_WAIT_RDY;
            end
         end
         ST_WAIT_RDY: begin
            if (req_s) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else if (READY_IN) begin
               state_d = ST_RUN;
               ack_d   = ~ack_q;
            end
         end
         ST_RUN: begin
            if (req_s) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_HOLD;
            cnt_d   = '0;
         end
      endcase
   end

   // State and outputs registered together; outputs decode the state being entered
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_HOLD;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         out_rst_q <= 1'b1;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         out_rst_q <= (state_d == ST_HOLD) || (state_d == ST_WAIT_REL);
         busy_q    <= (state_d != ST_RUN);
      end
   end

   assign OUT_RST    = out_rst_q;
   assign OUT_RST_N  = ~out_rst_q;
   assign BUSY       = busy_q;
   assign ACK_TOGGLE = ack_q;

endmodule
